tick_burst_ctrl: RTL and testbench
==================================

TICK_BURST_CTRL -- requirements
Module: tick_burst_ctrl

Interface
REQ-001 Parameter DIV_W, default 16, width of divisor register and phase counter.
REQ-002 Parameter CNT_W, default 16, width of burst-count register.
REQ-003 Parameter DEFAULT_DIV, default 10, divisor value loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cfg_valid  input  1  configuration offer.
REQ-007 cfg_ready  output  1  configuration accepted when high with cfg_valid.
REQ-008 cfg_divisor  input  DIV_W  tick period in clk cycles.
REQ-009 cfg_count  input  CNT_W  ticks per burst; 0 = continuous.
REQ-010 start  input  1  begin burst (level sampled per cycle).
REQ-011 stop  input  1  abort burst.
REQ-012 tick_out  output  1  registered one-cycle tick pulse.
REQ-013 busy  output  1  high in RUN state.
REQ-014 done  output  1  one-cycle pulse on normal burst completion.
REQ-015 ticks_left  output  CNT_W  remaining ticks in current burst.

Function
REQ-016 The block SHALL implement states IDLE, RUN, DONE; encoding free.
REQ-017 cfg_ready SHALL equal 1 exactly when state is IDLE; handshake = cfg_valid & cfg_ready.
REQ-018 On handshake the block SHALL latch div_reg <= max(cfg_divisor,1) and cnt_reg <= cfg_count.
REQ-019 IDLE->RUN on start; if handshake and start occur in the same cycle, the burst SHALL use the newly latched values.
REQ-020 On IDLE->RUN the block SHALL clear the phase counter to 0 and load ticks_left <= cnt_reg (or new cfg_count per REQ-019).
REQ-021 In RUN the phase counter SHALL increment each cycle and, when phase == div_reg-1, wrap to 0 and set tick_out <= 1 for exactly one cycle; otherwise tick_out <= 0.
REQ-022 Latency: start sampled at edge k SHALL produce first tick_out high in the cycle following edge k+div_reg; subsequent ticks every div_reg cycles.
REQ-023 div_reg = 1 (including cfg_divisor = 0) SHALL yield tick_out high every RUN cycle.
REQ-024 Finite burst (cnt_reg != 0): ticks_left SHALL decrement on each tick; the tick that brings it to 0 SHALL move state RUN->DONE at the same edge.
REQ-025 DONE SHALL last one cycle with done = 1, then return to IDLE; the final tick_out is high in that same cycle.
REQ-026 Continuous burst (cnt_reg == 0): ticks_left SHALL stay 0, ticks continue until stop.
REQ-027 stop in RUN SHALL move to IDLE at the next edge, suppress any tick due at that edge, clear ticks_left, and not assert done.
REQ-028 stop SHALL have priority over a simultaneous tick or final-tick completion.
REQ-029 start in RUN or DONE, stop in IDLE or DONE, and cfg_valid outside IDLE SHALL be ignored with no state change.
REQ-030 busy SHALL be 1 in RUN only; 0 in IDLE and DONE.
REQ-031 Phase counter and ticks_left arithmetic SHALL be unsigned, never wrap below 0.

Reset
REQ-032 While rst = 1 at a rising edge: state <= IDLE, div_reg <= DEFAULT_DIV, cnt_reg <= 0, phase <= 0, ticks_left <= 0, tick_out <= 0, done <= 0.
REQ-033 rst SHALL override all other inputs, including mid-burst; no done pulse follows a reset.
REQ-034 cfg_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-035 Reset then start with defaults (div 10, count 0) -> tick_out pulses every 10 cycles, first 10 cycles after start, busy = 1 continuously.
REQ-036 cfg div 3 count 4 + start same cycle -> exactly 4 ticks 3 cycles apart, done high with 4th tick, busy 0 next cycle, cfg_ready 1.
REQ-037 cfg div 0 count 2 -> ticks on two consecutive cycles, then done.
REQ-038 div 5 count 10, stop asserted at the edge the 2nd tick is due -> no 2nd tick, no done, ticks_left 0, IDLE.
REQ-039 div 4 count 3, rst high mid-burst -> all outputs 0, div_reg back to 10; cfg_valid during RUN ignored (divisor unchanged).

Source files
------------

// File: rtl/tick_burst_ctrl.sv
// tick_burst_ctrl: programmable tick generator that emits bursts of
// one-cycle pulses. The divisor sets the tick period in clk cycles, and the
// count sets the number of ticks per burst (0 means run until stopped).
// Configuration is accepted only while idle.
module tick_burst_ctrl #(
  parameter int DIV_W       = 16,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_divisor,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             tick_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ticks_left
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [DIV_W-1:0] phase;

  // Config is only offered to the outside while idle; busy marks an active burst.
  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);

  // Burst controller: config latch, phase counter, tick/done pulses and countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_reg    <= DIV_W'(DEFAULT_DIV);
      cnt_reg    <= '0;
      phase      <= '0;
      ticks_left <= '0;
      tick_out   <= 1'b0;
      done       <= 1'b0;
    end else begin
      tick_out <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            // A zero divisor is treated as 1 so the phase compare stays valid.
            div_reg <= (cfg_divisor == '0) ? DIV_W'(1) : cfg_divisor;
            cnt_reg <= cfg_count;
          end
          if (start) begin
            state      <= RUN;
            phase      <= '0;
            // A config offered in the same cycle as start applies to this burst.
            ticks_left <= cfg_valid ? cfg_count : cnt_reg;
          end
        end
        RUN: begin
          if (stop) begin
            // Abort wins over any tick or completion due at this edge.
            state      <= IDLE;
            phase      <= '0;
            ticks_left <= '0;
          end else if (phase == div_reg - DIV_W'(1)) begin
            phase    <= '0;
            tick_out <= 1'b1;
            // ticks_left is 0 only in continuous mode, where it must stay 0.
            if (ticks_left != '0) begin
              ticks_left <= ticks_left - CNT_W'(1);
              if (ticks_left == CNT_W'(1)) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end else begin
            phase <= phase + DIV_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_burst_ctrl.sv
// Directed testbench for tick_burst_ctrl with hand-computed expectations.
module tb_tick_burst_ctrl;

  localparam int DIV_W = 16;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_divisor;
  logic [CNT_W-1:0] cfg_count;
  logic             start;
  logic             stop;
  logic             tick_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] ticks_left;

  int total = 0;
  int bad   = 0;

  tick_burst_ctrl #(
    .DIV_W      (DIV_W),
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_divisor(cfg_divisor),
    .cfg_count  (cfg_count),
    .start      (start),
    .stop       (stop),
    .tick_out   (tick_out),
    .busy       (busy),
    .done       (done),
    .ticks_left (ticks_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report a mismatch.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then park on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input logic t, input logic b,
                          input logic d, input int tl, input logic r);
    chk({tag, ".tick"},  tick_out,   t);
    chk({tag, ".busy"},  busy,       b);
    chk({tag, ".done"},  done,       d);
    chk({tag, ".left"},  ticks_left, tl);
    chk({tag, ".ready"}, cfg_ready,  r);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_divisor = '0; cfg_count = '0;
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    chk_outs("reset", 0, 0, 0, 0, 1);

    // Defaults: divisor 10, continuous. start held high to show it is ignored in RUN.
    start = 1'b1;
    step();
    chk_outs("dflt.k", 0, 1, 0, 0, 0);
    for (int j = 1; j <= 30; j++) begin
      step();
      chk($sformatf("dflt.tick%0d", j), tick_out, (j % 10) == 0);
      chk($sformatf("dflt.busy%0d", j), busy, 1'b1);
      chk($sformatf("dflt.left%0d", j), ticks_left, 0);
    end
    start = 1'b0;
    stop  = 1'b1;
    step();
    stop = 1'b0;
    chk_outs("dflt.stop", 0, 0, 0, 0, 1);

    // div 3, count 4, config and start in the same cycle.
    cfg_valid = 1'b1; cfg_divisor = 16'd3; cfg_count = 16'd4; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    chk_outs("b34.k", 0, 1, 0, 4, 0);
    for (int j = 1; j <= 12; j++) begin
      step();
      chk_outs($sformatf("b34.%0d", j), (j % 3) == 0, j < 12, j == 12, 4 - j / 3, 0);
    end
    step();
    chk_outs("b34.after", 0, 0, 0, 0, 1);

    // div 0 (treated as 1), count 2: back-to-back ticks then done.
    cfg_valid = 1'b1; cfg_divisor = 16'd0; cfg_count = 16'd2; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    chk_outs("d0.k", 0, 1, 0, 2, 0);
    step();
    chk_outs("d0.1", 1, 1, 0, 1, 0);
    step();
    chk_outs("d0.2", 1, 0, 1, 0, 0);
    step();
    chk_outs("d0.3", 0, 0, 0, 0, 1);

    // div 5, count 10 configured first; stop lands on the edge of the 2nd tick.
    cfg_valid = 1'b1; cfg_divisor = 16'd5; cfg_count = 16'd10;
    step();
    cfg_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_outs("stp.k", 0, 1, 0, 10, 0);
    for (int j = 1; j <= 9; j++) begin
      step();
      chk($sformatf("stp.tick%0d", j), tick_out, j == 5);
      chk($sformatf("stp.left%0d", j), ticks_left, (j >= 5) ? 9 : 10);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_outs("stp.10", 0, 0, 0, 0, 1);
    step();
    chk_outs("stp.11", 0, 0, 0, 0, 1);

    // div 4, count 3; config offered mid-burst is ignored, then reset mid-burst.
    cfg_valid = 1'b1; cfg_divisor = 16'd4; cfg_count = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    cfg_divisor = 16'd7; cfg_count = 16'd9;
    step();
    chk("rb.ready_run", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    step();
    step();
    chk_outs("rb.3", 0, 1, 0, 3, 0);
    step();
    chk_outs("rb.4", 1, 1, 0, 2, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_outs("rb.rst", 0, 0, 0, 0, 1);
    // Restart without config: divisor must be back to 10 and count 0.
    start = 1'b1;
    step();
    start = 1'b0;
    chk_outs("rb.k", 0, 1, 0, 0, 0);
    for (int j = 1; j <= 10; j++) begin
      step();
      chk($sformatf("rb.tick%0d", j), tick_out, j == 10);
      chk($sformatf("rb.done%0d", j), done, 1'b0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_outs("rb.stop", 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
